// File: rtl/ibus_sram_responder.sv
// Instruction SRAM responder with loader port; the optional IBUS_MISALIGN_CHECK_EN flags misaligned fetches.
// Latency: data_ok LATENCY cycles after acceptance; backpressure: one fetch outstanding, addr_ok held low until its response cycle.
package ibus_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

module ibus_sram_responder
    import ibus_pkg::*;
#(
    parameter int AW      = 12,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  ibus_req_t       ireq,
    output ibus_resp_t      iresp,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [31:0]     load_data,
    output logic            misalign
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("ibus_sram_responder: LATENCY must be within 1..15");
    end
    if (AW < 1 || AW > 29) begin : g_bad_aw
        $error("ibus_sram_responder: AW must be within 1..29");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic [31:0]    data_q;
    logic [31:0]    mem [0:(1<<AW)-1];

    logic [AW-1:0]  idx;
    logic           resp_now;
    logic           accept;
    logic [31:0]    fetch_word;
    logic           unused_addr_bits;

    assign idx              = ireq.addr[AW+1:2];
    assign unused_addr_bits = ^{ireq.addr[31:AW+2], ireq.addr[1:0]};
    assign resp_now         = (state_q == BUSY) && (cnt_q == 4'd0);
    // A request can slot in on the response cycle, which is what gives one word per cycle at LATENCY=1.
    assign accept           = !reset && ireq.valid && ((state_q == IDLE) || resp_now);

    assign iresp.addr_ok = accept;
    assign iresp.data_ok = !reset && resp_now;
    assign iresp.data    = (!reset && resp_now) ? data_q : 32'h0;

    // Store has no reset; the loader may write in any state. Reads see the pre-write word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

`ifdef IBUS_MISALIGN_CHECK_EN
    logic misalign_q;
    logic bad_align;

    assign bad_align = (ireq.addr[1:0] != 2'b00);
    assign misalign  = misalign_q;

    always_comb begin
        fetch_word = mem[idx];
        if (bad_align) begin
            fetch_word = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (accept && bad_align) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign misalign = 1'b0;

    always_comb begin
        fetch_word = mem[idx];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 32'h0;
        end else if (accept) begin
            state_q <= BUSY;
            cnt_q   <= 4'(LATENCY - 1);
            data_q  <= fetch_word;
        end else if (state_q == BUSY) begin
            if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end else begin
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ibus_sram_responder.sv
// Directed bench for ibus_sram_responder at LATENCY 1, 3 and 4 sharing one request/loader stimulus.
module tb_ibus_sram_responder;
    import ibus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    logic        load_en;
    logic [11:0] load_addr;
    logic [31:0] load_data;

    ibus_resp_t  resp1, resp3, resp4;
    logic        mis1, mis3, mis4;

    int total = 0;
    int bad   = 0;

`ifdef IBUS_MISALIGN_CHECK_EN
    localparam logic [31:0] MIS_DATA = 32'h0;
    localparam logic [31:0] MIS_FLAG = 32'h1;
`else
    localparam logic [31:0] MIS_DATA = 32'h2409_0002;
    localparam logic [31:0] MIS_FLAG = 32'h0;
`endif

    always #5 clk = ~clk;

    ibus_sram_responder #(.AW(12), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(resp1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .misalign(mis1)
    );
    ibus_sram_responder #(.AW(12), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(resp3),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .misalign(mis3)
    );
    ibus_sram_responder #(.AW(12), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(resp4),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .misalign(mis4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive just after the rising edge, sample on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic load_word(input logic [11:0] a, input logic [31:0] d);
        nxt();
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        nxt();
        load_en   = 1'b0;
    endtask

    task automatic do_reset();
        nxt();
        reset      = 1'b1;
        ireq.valid = 1'b0;
        nxt();
        nxt();
        reset      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        ireq      = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        // Reset state, with valid held to show addr_ok stays low
        nxt();
        ireq.valid = 1'b1;
        smp();
        chk("rst_addr_ok", {31'b0, resp1.addr_ok}, 32'h0);
        chk("rst_data_ok", {31'b0, resp1.data_ok}, 32'h0);
        chk("rst_data",    resp1.data, 32'h0);
        chk("rst_misalign", {31'b0, mis1}, 32'h0);
        ireq.valid = 1'b0;

        // Fill store while reset is held
        load_word(12'd0, 32'h2408_0001);
        load_word(12'd1, 32'h2409_0002);
        load_word(12'd2, 32'hDEAD_BEEF);
        load_word(12'd5, 32'h2222_2222);
        nxt();
        reset = 1'b0;

        // LATENCY=1 back-to-back: addr 0 then 4
        nxt(); ireq.valid = 1'b1; ireq.addr = 32'h0; smp();
        chk("b2b_T_addr_ok", {31'b0, resp1.addr_ok}, 32'h1);
        chk("b2b_T_data_ok", {31'b0, resp1.data_ok}, 32'h0);
        nxt(); ireq.addr = 32'h4; smp();
        chk("b2b_T1_addr_ok", {31'b0, resp1.addr_ok}, 32'h1);
        chk("b2b_T1_data_ok", {31'b0, resp1.data_ok}, 32'h1);
        chk("b2b_T1_data", resp1.data, 32'h2408_0001);
        nxt(); ireq.valid = 1'b0; smp();
        chk("b2b_T2_data_ok", {31'b0, resp1.data_ok}, 32'h1);
        chk("b2b_T2_data", resp1.data, 32'h2409_0002);
        nxt(); smp();
        chk("b2b_T3_data_ok", {31'b0, resp1.data_ok}, 32'h0);
        chk("b2b_T3_data", resp1.data, 32'h0);

        // LATENCY=3 single request at addr 8, valid held through T+2
        do_reset();
        nxt(); ireq.valid = 1'b1; ireq.addr = 32'h8; smp();
        chk("l3_T_addr_ok", {31'b0, resp3.addr_ok}, 32'h1);
        nxt(); smp();
        chk("l3_T1_addr_ok", {31'b0, resp3.addr_ok}, 32'h0);
        chk("l3_T1_data_ok", {31'b0, resp3.data_ok}, 32'h0);
        nxt(); smp();
        chk("l3_T2_addr_ok", {31'b0, resp3.addr_ok}, 32'h0);
        chk("l3_T2_data_ok", {31'b0, resp3.data_ok}, 32'h0);
        nxt(); ireq.valid = 1'b0; smp();
        chk("l3_T3_data_ok", {31'b0, resp3.data_ok}, 32'h1);
        chk("l3_T3_data", resp3.data, 32'hDEAD_BEEF);
        nxt(); smp();
        chk("l3_T4_data_ok", {31'b0, resp3.data_ok}, 32'h0);

        // Address alias: 0x4004 wraps to word 1
        do_reset();
        nxt(); ireq.valid = 1'b1; ireq.addr = 32'h0000_4004; smp();
        chk("alias_addr_ok", {31'b0, resp1.addr_ok}, 32'h1);
        nxt(); ireq.valid = 1'b0; smp();
        chk("alias_data", resp1.data, 32'h2409_0002);

        // Same-cycle load and fetch of word 5: read-before-write
        do_reset();
        nxt();
        ireq.valid = 1'b1; ireq.addr = 32'd20;
        load_en = 1'b1; load_addr = 12'd5; load_data = 32'h1111_1111;
        smp();
        chk("rbw_addr_ok", {31'b0, resp1.addr_ok}, 32'h1);
        nxt(); load_en = 1'b0; smp();
        chk("rbw_old_data_ok", {31'b0, resp1.data_ok}, 32'h1);
        chk("rbw_old_data", resp1.data, 32'h2222_2222);
        nxt(); ireq.valid = 1'b0; smp();
        chk("rbw_new_data", resp1.data, 32'h1111_1111);

        // LATENCY=4 with reset at T+2: pending response is dropped
        do_reset();
        nxt(); ireq.valid = 1'b1; ireq.addr = 32'h0; smp();
        chk("rst4_T_addr_ok", {31'b0, resp4.addr_ok}, 32'h1);
        nxt(); ireq.valid = 1'b0; smp();
        chk("rst4_T1_data_ok", {31'b0, resp4.data_ok}, 32'h0);
        nxt(); reset = 1'b1; ireq.valid = 1'b1; smp();
        chk("rst4_T2_addr_ok", {31'b0, resp4.addr_ok}, 32'h0);
        chk("rst4_T2_data_ok", {31'b0, resp4.data_ok}, 32'h0);
        chk("rst4_T2_data", resp4.data, 32'h0);
        nxt(); ireq.valid = 1'b0; smp();
        chk("rst4_T3_data_ok", {31'b0, resp4.data_ok}, 32'h0);
        nxt(); reset = 1'b0; smp();
        chk("rst4_T4_data_ok", {31'b0, resp4.data_ok}, 32'h0);
        nxt(); ireq.valid = 1'b1; ireq.addr = 32'h4; smp();
        chk("rst4_new_addr_ok", {31'b0, resp4.addr_ok}, 32'h1);
        nxt(); ireq.valid = 1'b0;
        nxt();
        nxt(); smp();
        chk("rst4_new_T3_data_ok", {31'b0, resp4.data_ok}, 32'h0);
        nxt(); smp();
        chk("rst4_new_T4_data_ok", {31'b0, resp4.data_ok}, 32'h1);
        chk("rst4_new_T4_data", resp4.data, 32'h2409_0002);

        // Misaligned fetch at addr 6
        do_reset();
        nxt(); ireq.valid = 1'b1; ireq.addr = 32'h6; smp();
        chk("mis_T_addr_ok", {31'b0, resp1.addr_ok}, 32'h1);
        chk("mis_T_flag", {31'b0, mis1}, 32'h0);
        nxt(); ireq.valid = 1'b0; smp();
        chk("mis_T1_data_ok", {31'b0, resp1.data_ok}, 32'h1);
        chk("mis_T1_data", resp1.data, MIS_DATA);
        chk("mis_T1_flag", {31'b0, mis1}, MIS_FLAG);
        nxt(); nxt(); smp();
        chk("mis_T3_flag", {31'b0, mis1}, MIS_FLAG);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ibus_sram_responder.md
Name: ibus_sram_responder

Overview:
- Instruction-bus responder: the memory side of the ibus_req_t/ibus_resp_t handshake that the fetch stage drives.
- Holds a word-addressed instruction store and accepts one outstanding fetch at a time.
- Returns each word a fixed, parameterised number of cycles after acceptance.
- Used as the core's instruction memory in simulation and FPGA bring-up; a loader port fills it before reset release.

Parameters:
- AW, 12: word-address bits; store depth = 2**AW words of 32 bits.
- LATENCY, 1: cycles from request acceptance to data_ok; legal range 1..15 (elaboration error outside this range).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ireq  input  ibus_req_t  fetch request; valid, addr[31:0].
- iresp  output  ibus_resp_t  response; addr_ok, data_ok, data[31:0].
- load_en  input  1  loader write strobe.
- load_addr  input  AW  loader word index.
- load_data  input  32  loader write data.
- misalign  output  1  sticky misaligned-fetch flag; constant 0 unless the optional feature is compiled in.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, cnt=0, data register=0, misalign=0. Outputs addr_ok=0, data_ok=0, data=0.
- Store contents are not affected by reset.
- Reset asserted mid-transaction drops the pending response; no data_ok is issued for it.
- Indexing: word index = ireq.addr[AW+1:2]. Upper address bits are ignored, so addresses alias/wrap modulo 2**(AW+2).
- States:
  - IDLE: no request pending.
  - BUSY: request pending; cnt counts down to the response.
- addr_ok (combinational) = ireq.valid && (state==IDLE || (state==BUSY && cnt==0)).
- Acceptance (addr_ok=1 at an edge):
  - data register <= store[index], sampled at that edge.
  - cnt <= LATENCY-1.
  - state <= BUSY.
- BUSY with cnt!=0: cnt decrements; data_ok=0.
- BUSY with cnt==0:
  - data_ok=1 and data=data register for exactly one cycle.
  - If no new acceptance that cycle, state <= IDLE.
  - If a new request is accepted in the same cycle, state stays BUSY and cnt reloads, giving back-to-back throughput.
- Timing: request accepted at cycle T gives data_ok at T+LATENCY. LATENCY=1 sustains one word per cycle.
- data is 0 whenever data_ok=0.
- Requester rule: hold ireq.valid and addr stable until addr_ok. The responder never drops an accepted request.
- Loader: load_en writes store[load_addr] <= load_data at the edge, regardless of state.
- Loader/fetch same cycle, same word: the fetch returns the old word (read-before-write). A later write does not alter an already-latched response.

Optional Feature:
- Macro: IBUS_MISALIGN_CHECK_EN.
- Defined:
  - An accepted request with addr[1:0]!=0 still completes the handshake normally, but its data is 32'h0.
  - misalign is set the cycle after acceptance and stays 1 until reset.
- Undefined:
  - addr[1:0] is ignored and the word is returned as if aligned.
  - misalign is tied 0.

Test Plan:
- Load store[0]=32'h2408_0001 and store[1]=32'h2409_0002; hold valid=1, LATENCY=1, addr 0 then 4 -> addr_ok on T and T+1; data_ok on T+1 and T+2 with data 24080001, then 24090002.
- LATENCY=3, single request at addr 8 with store[2]=32'hDEAD_BEEF:
  - addr_ok at T only, and addr_ok stays 0 at T+1 and T+2 while valid is still held.
  - data_ok=1 only at T+3 with data DEADBEEF.
- AW=12, request addr 32'h0000_4004 -> returns store[1] (alias/wrap).
- Same-cycle load_en to word 5 (new=32'h1111_1111, old=32'h2222_2222) and fetch of addr 20 -> data 22222222; the next fetch of addr 20 -> 11111111.
- LATENCY=4, assert reset at T+2 after acceptance at T -> no data_ok at T+4; all outputs 0 during reset; the next request after reset behaves normally.
- With IBUS_MISALIGN_CHECK_EN, fetch addr 32'h6 -> data_ok with data 0 and misalign=1 persisting. Without the macro -> data=store[1] and misalign=0.
